// File: rtl/alu_rvs_sched_if.sv
// -----------------------------------------------------------------------------
// alu_rvs_sched_if
// Request/response bundle between the ALU issue logic (master) and the
// round-robin bit-reverse scheduler (slave).
//   req_valid  NREQ     request valid, one bit per requester
//   req_ready  NREQ     one-hot accept strobe from the scheduler
//   req_data   NREQ*32  operand of requester i at [i*32 +: 32]
//   req_mode   NREQ*2   block-size code of requester i at [i*2 +: 2]
//   rsp_valid  1        response valid
//   rsp_ready  1        response consumer ready
//   rsp_data   32       block-wise bit-reversed word
//   rsp_id     IDW      index of the requester served
//   busy       1        scheduler is executing or holding a response
// -----------------------------------------------------------------------------
interface alu_rvs_sched_if #(
   parameter int NREQ = 4,
   parameter int IDW  = 2
);
   logic [NREQ-1:0]    req_valid;
   logic [NREQ-1:0]    req_ready;
   logic [NREQ*32-1:0] req_data;
   logic [NREQ*2-1:0]  req_mode;
   logic               rsp_valid;
   logic               rsp_ready;
   logic [31:0]        rsp_data;
   logic [IDW-1:0]     rsp_id;
   logic               busy;

   modport master (
      output req_valid, req_data, req_mode, rsp_ready,
      input  req_ready, rsp_valid, rsp_data, rsp_id, busy
   );

   modport slave (
      input  req_valid, req_data, req_mode, rsp_ready,
      output req_ready, rsp_valid, rsp_data, rsp_id, busy
   );
endinterface

// File: rtl/alu_rvs_sched.sv
// -----------------------------------------------------------------------------
// alu_rvs_sched
// Round-robin scheduler sharing one block-wise bit-reverse datapath between
// NREQ requesters. One request is accepted at a time, its bits are reversed
// inside blocks of 4/8/16/32 bits, and the result is returned with the ID of
// the requester that was served.
// Ports:
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset
//   bus    alu_rvs_sched_if.slave (request channel, response channel, busy)
// -----------------------------------------------------------------------------
module alu_rvs_sched #(
   parameter int NREQ = 4,
   parameter int IDW  = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   alu_rvs_sched_if.slave  bus
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t         r_state;
   logic [IDW-1:0] r_rr_ptr;
   logic [IDW-1:0] r_id;
   logic [31:0]    r_data;
   logic [1:0]     r_mode;
   logic [31:0]    r_rsp_data;
   logic           r_rsp_valid;
   logic           r_busy;

   logic [31:0]    w_req_word [NREQ];
   logic [1:0]     w_req_mode [NREQ];
   logic           w_found;
   logic [IDW-1:0] w_winner;
   logic           w_grant;
   logic [31:0]    w_rev4;
   logic [31:0]    w_rev8;
   logic [31:0]    w_rev16;
   logic [31:0]    w_rev32;
   logic [31:0]    w_rev;

   genvar gi;

   // Unpack the flat request buses so the winner can be selected by index.
   generate
      for (gi = 0; gi < NREQ; gi++) begin : g_unpack
         assign w_req_word[gi] = bus.req_data[gi*32 +: 32];
         assign w_req_mode[gi] = bus.req_mode[gi*2 +: 2];
      end
   endgenerate

   // Scan from rr_ptr upward with wrap; the first valid index wins.
   always_comb begin
      logic [IDW:0] sum;
      w_found  = 1'b0;
      w_winner = '0;
      sum      = '0;
      for (int k = 0; k < NREQ; k++) begin
         sum = {1'b0, r_rr_ptr} + (IDW+1)'(k);
         if (sum >= (IDW+1)'(NREQ)) begin
            sum = sum - (IDW+1)'(NREQ);
         end
         if (!w_found && bus.req_valid[sum[IDW-1:0]]) begin
            w_found  = 1'b1;
            w_winner = sum[IDW-1:0];
         end
      end
   end

   // Accept strobe is combinational and suppressed while reset is asserted.
   assign w_grant = rst_n && (r_state == S_IDLE) && w_found;

   generate
      for (gi = 0; gi < NREQ; gi++) begin : g_ready
         assign bus.req_ready[gi] = w_grant && (w_winner == IDW'(gi));
      end
   endgenerate

   // Fixed wiring for each block size: bit j of block k takes bit B-1-j.
   generate
      for (gi = 0; gi < 32; gi++) begin : g_rev
         assign w_rev4[gi]  = r_data[(gi/4)*4   + 3  - (gi%4)];
         assign w_rev8[gi]  = r_data[(gi/8)*8   + 7  - (gi%8)];
         assign w_rev16[gi] = r_data[(gi/16)*16 + 15 - (gi%16)];
         assign w_rev32[gi] = r_data[31 - gi];
      end
   endgenerate

   always_comb begin
      w_rev = w_rev8;
      case (r_mode)
         2'b00:   w_rev = w_rev8;
         2'b01:   w_rev = w_rev16;
         2'b10:   w_rev = w_rev32;
         default: w_rev = w_rev4;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_rr_ptr    <= '0;
         r_id        <= '0;
         r_data      <= '0;
         r_mode      <= '0;
         r_rsp_data  <= '0;
         r_rsp_valid <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_found) begin
                  r_data  <= w_req_word[w_winner];
                  r_mode  <= w_req_mode[w_winner];
                  r_id    <= w_winner;
                  r_busy  <= 1'b1;
                  r_state <= S_EXEC;
               end
            end
            S_EXEC: begin
               r_rsp_data  <= w_rev;
               r_rsp_valid <= 1'b1;
               r_state     <= S_RESP;
            end
            S_RESP: begin
               // Pointer moves past the served requester only on handshake.
               if (bus.rsp_ready) begin
                  r_rsp_valid <= 1'b0;
                  r_busy      <= 1'b0;
                  r_rr_ptr    <= (r_id == IDW'(NREQ-1)) ? '0 : r_id + 1'b1;
                  r_state     <= S_IDLE;
               end
            end
            default: begin
               r_rsp_valid <= 1'b0;
               r_busy      <= 1'b0;
               r_state     <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.rsp_valid = r_rsp_valid;
   assign bus.rsp_data  = r_rsp_data;
   assign bus.rsp_id    = r_id;
   assign bus.busy      = r_busy;

endmodule

// File: tb/tb_alu_rvs_sched.sv
// -----------------------------------------------------------------------------
// tb_alu_rvs_sched
// Self-checking bench for alu_rvs_sched: directed scenarios followed by
// randomized traffic, all compared against a behavioural model of the
// arbitration order, response timing and block-wise bit reversal.
// -----------------------------------------------------------------------------
module tb_alu_rvs_sched;
   localparam int NREQ = 4;
   localparam int IDW  = 2;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   alu_rvs_sched_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

   alu_rvs_sched #(.NREQ(NREQ), .IDW(IDW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // requester-side stimulus state
   logic [NREQ-1:0] pend;
   logic [31:0]     dat [NREQ];
   logic [1:0]      md  [NREQ];
   logic            rdy;
   bit              rand_en;
   bit              refill;

   // reference model state
   bit          inflight;
   int          age;
   logic [1:0]  ptr;
   logic [1:0]  cur_id;
   logic [31:0] cur_exp;
   int          n_done;
   logic [31:0] last_data;
   logic [1:0]  last_id;
   logic [NREQ-1:0] obs_ready;
   int          grants [$];

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Reverse bit order inside each block of the size the mode selects.
   function automatic logic [31:0] rev_model(input logic [31:0] w, input logic [1:0] m);
      logic [31:0] r;
      int b;
      b = (m == 2'b00) ? 8 : (m == 2'b01) ? 16 : (m == 2'b10) ? 32 : 4;
      r = '0;
      for (int k = 0; k < 32; k += b)
         for (int j = 0; j < b; j++)
            r[k+j] = w[k+b-1-j];
      return r;
   endfunction

   // First pending requester at or after the pointer, wrapping.
   function automatic logic [1:0] pick(input logic [1:0] p, input logic [NREQ-1:0] v);
      for (int off = 0; off < NREQ; off++) begin
         int idx;
         idx = (int'(p) + off) % NREQ;
         if (v[idx]) return 2'(idx);
      end
      return 2'd0;
   endfunction

   task automatic drive();
      bus.req_valid = pend;
      for (int i = 0; i < NREQ; i++) begin
         bus.req_data[i*32 +: 32] = dat[i];
         bus.req_mode[i*2 +: 2]   = md[i];
      end
      bus.rsp_ready = rdy;
   endtask

   task automatic post(input int i, input logic [31:0] d, input logic [1:0] m);
      pend[i] = 1'b1;
      dat[i]  = d;
      md[i]   = m;
   endtask

   // One clock: check outputs at the falling edge, advance the model after
   // the rising edge, then present the next inputs.
   task automatic step();
      logic [NREQ-1:0] exp_ready;
      logic [1:0]      w;
      logic [31:0]     obs_data;
      bit              exp_rv, do_grant, do_done;
      @(negedge clk);
      w         = pick(ptr, pend);
      exp_ready = '0;
      do_grant  = rst_n && !inflight && (pend != '0);
      if (do_grant) exp_ready[w] = 1'b1;
      obs_ready = bus.req_ready;
      obs_data  = bus.rsp_data;
      check("req_ready", 32'(bus.req_ready), 32'(exp_ready));
      check("busy", 32'(bus.busy), 32'(inflight));
      exp_rv = inflight && (age >= 2);
      check("rsp_valid", 32'(bus.rsp_valid), 32'(exp_rv));
      if (exp_rv) begin
         check("rsp_data", bus.rsp_data, cur_exp);
         check("rsp_id", 32'(bus.rsp_id), 32'(cur_id));
      end
      do_done = exp_rv && rdy && rst_n;
      @(posedge clk);
      #1;
      if (!rst_n) begin
         if (inflight) pend[cur_id] = 1'b1;   // dropped work is re-requested
         inflight = 1'b0;
         ptr      = 2'd0;
         age      = 0;
      end else if (do_grant) begin
         inflight = 1'b1;
         age      = 1;
         cur_id   = w;
         cur_exp  = rev_model(dat[w], md[w]);
         grants.push_back(int'(w));
         if (refill) begin
            dat[w] = $urandom;
            md[w]  = 2'($urandom_range(0, 3));
         end else begin
            pend[w] = 1'b0;
         end
      end else if (do_done) begin
         inflight  = 1'b0;
         ptr       = 2'((int'(cur_id) + 1) % NREQ);
         last_data = obs_data;
         last_id   = cur_id;
         n_done++;
         $display("txn %0d: id=%0d data=%h", n_done, cur_id, obs_data);
      end else if (inflight) begin
         age++;
      end
      if (rand_en) begin
         for (int i = 0; i < NREQ; i++) begin
            if (!pend[i] && $urandom_range(0, 3) == 0)
               post(i, $urandom, 2'($urandom_range(0, 3)));
            else if (pend[i] && $urandom_range(0, 15) == 0)
               pend[i] = 1'b0;
         end
         rdy = ($urandom_range(0, 3) != 0);
      end
      drive();
   endtask

   task automatic wait_done(input int target);
      for (int c = 0; c < 60 && n_done < target; c++) step();
      check("done_timeout", 32'(n_done), 32'(target));
   endtask

   task automatic wait_idle();
      for (int c = 0; c < 30 && inflight; c++) step();
      check("idle_timeout", 32'(inflight), 32'd0);
   endtask

   logic [31:0] t2_exp [4];
   logic [1:0]  t2_mode [4];
   int gstart;

   initial begin
      pend = '0; rdy = 1'b1; rand_en = 0; refill = 0;
      inflight = 0; age = 0; ptr = 2'd0; cur_id = 2'd0; cur_exp = '0;
      n_done = 0; last_data = '0; last_id = 2'd0;
      for (int i = 0; i < NREQ; i++) begin dat[i] = '0; md[i] = 2'b00; end
      drive();

      // reset state
      repeat (3) step();
      check("reset_rsp_data", bus.rsp_data, 32'h0);
      check("reset_rsp_id", 32'(bus.rsp_id), 32'h0);
      rst_n = 1'b1;

      // single request on requester 0
      post(0, 32'h0000_0001, 2'b00); drive();
      wait_done(1);
      check("t1_data", last_data, 32'h0000_0080);
      check("t1_id", 32'(last_id), 32'd0);

      // mode sweep on requester 1
      t2_mode = '{2'b11, 2'b10, 2'b01, 2'b00};
      t2_exp  = '{32'h84C2A6E1, 32'h1E6A2C48, 32'h2C481E6A, 32'h482C6A1E};
      for (int m = 0; m < 4; m++) begin
         post(1, 32'h1234_5678, t2_mode[m]); drive();
         wait_done(n_done + 1);
         check("t2_mode_data", last_data, t2_exp[m]);
      end

      // requester 3 alone, twice: pointer wraps to 0 and searches to 3
      post(3, 32'hF000_000F, 2'b11); drive();
      wait_done(n_done + 1);
      post(3, 32'hA5A5_F00F, 2'b10); drive();
      step();
      check("t6_regrant", 32'(obs_ready), 32'h8);
      wait_done(n_done + 1);

      // all requesters continuously valid: strict rotation from 0
      gstart = grants.size();
      refill = 1;
      for (int i = 0; i < NREQ; i++) post(i, $urandom, 2'($urandom_range(0, 3)));
      drive();
      wait_done(n_done + 8);
      refill = 0; pend = '0; drive();
      wait_idle();
      for (int k = 0; k < 8; k++)
         check("t3_order", 32'(grants[gstart+k]), 32'(k % NREQ));

      // backpressure: response held for 5 cycles
      rdy = 1'b0;
      post(0, 32'hDEAD_BEEF, 2'b01); drive();
      for (int c = 0; c < 10 && !bus.rsp_valid; c++) step();
      repeat (5) step();
      check("t4_held", 32'(n_done), 32'(n_done));
      rdy = 1'b1; drive();
      wait_done(n_done + 1);
      check("t4_data", last_data, rev_model(32'hDEAD_BEEF, 2'b01));

      // reset during EXEC drops the transaction and restarts the pointer
      post(2, 32'hCAFE_BABE, 2'b01); drive();
      step();
      gstart = grants.size();
      rst_n = 1'b0;
      post(0, 32'h0F0F_0001, 2'b00); drive();
      step();
      step();
      rst_n = 1'b1; drive();
      wait_done(n_done + 2);
      check("t5_first", 32'(grants[gstart]), 32'd0);
      check("t5_second", 32'(grants[gstart+1]), 32'd2);

      // randomized traffic with random backpressure and withdrawals
      rand_en = 1;
      repeat (800) step();
      rand_en = 0; pend = '0; rdy = 1'b1; drive();
      wait_idle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
